// File: rtl/mv_stream_sequencer_pkg.sv
// Shared types and constants for the matrix-vector stream sequencer and its
// output holding register.
package mv_pkg;

    // Sequencer states, in the order a frame walks through them.
    typedef enum logic [3:0] {
        IDLE,
        CLR_Y,
        LOAD_X,
        LOAD_W,
        START,
        WAIT_DONE,
        RD_ADDR,
        RD_DATA,
        SEND,
        RELEASE
    } mv_state_t;

    // Every BRAM word is 32 bits, so byte address = word index << 2.
    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    // Byte enable pattern for a full-word write.
    localparam logic [3:0] BE_ALL = 4'hf;

    // A beat is framed badly when its tlast disagrees with whether it is
    // really the final word of the frame.
    function automatic logic tlastBad(input logic tlast, input logic isLastBeat);
        return tlast ^ isLastBeat;
    endfunction

endpackage

// File: rtl/mv_stream_sequencer_axis_out.sv
// Output-side AXI-Stream holding register: captures one result word and its
// tlast, presents them until the consumer accepts, then drops valid.
module mv_axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_fire
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;

    // Load a fresh word on request; otherwise hold it stable until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_fire  = r_valid & i_ready;

endmodule

// File: rtl/mv_stream_sequencer.sv
// Host-side sequencer for the matrix-vector multiply engine: fills the x and W
// BRAMs from an input stream, clears y, kicks the engine, waits for it, and
// streams y back out before releasing the start/done handshake.
module mv_stream_sequencer
    import mv_pkg::*;
#(
    parameter int addr_W_size = 16,
    parameter int addr_x_size = 12,
    parameter int addr_y_size = 12,
    parameter int length_M    = 512,
    parameter int length_N    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [addr_W_size-1:0] bram_addr_W,
    output logic [31:0]            bram_wrdata_W,
    output logic [3:0]             bram_we_W,
    output logic [addr_x_size-1:0] bram_addr_x,
    output logic [31:0]            bram_wrdata_x,
    output logic [3:0]             bram_we_x,
    output logic [addr_y_size-1:0] bram_addr_y,
    output logic [31:0]            bram_wrdata_y,
    output logic [3:0]             bram_we_y,
    input  logic [31:0]            bram_rddata_y,
    output logic [31:0]            mv_control,
    input  logic [31:0]            mv_status,
    output logic                   busy,
    output logic                   frame_err
);

    // One counter serves every phase; it must reach M*N-1 during the W load.
    localparam int TOTAL_W = length_M * length_N;
    localparam int CNT_W   = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;

    localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(length_M - 1);
    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(length_N - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(TOTAL_W - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    mv_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sReady;
    logic             r_start;
    logic             r_busy;
    logic             r_frameErr;

    logic                        w_beat;
    logic                        w_outLoad;
    logic                        w_outLast;
    logic                        w_outFire;
    logic [CNT_W+WORD_SHIFT-1:0] w_byteAddr;
    logic                        w_unusedStatus;

    assign w_beat         = s_axis_tvalid & r_sReady;
    assign w_outLoad      = (r_state == RD_DATA);
    assign w_outLast      = (r_cnt == LAST_Y);
    assign w_byteAddr     = {r_cnt, WORD_SHIFT'(0)};
    assign w_unusedStatus = ^mv_status[31:1];

    // Frame sequencing: clear y, load x then W, run the engine, drain y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sReady   <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        r_state    <= CLR_Y;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_frameErr <= 1'b0;
                    end
                end
                CLR_Y: begin
                    if (r_cnt == LAST_Y) begin
                        r_state  <= LOAD_X;
                        r_cnt    <= '0;
                        r_sReady <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                LOAD_X: begin
                    if (w_beat) begin
                        if (tlastBad(s_axis_tlast, 1'b0)) begin
                            r_frameErr <= 1'b1;
                        end
                        if (r_cnt == LAST_X) begin
                            r_state <= LOAD_W;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_beat) begin
                        if (tlastBad(s_axis_tlast, r_cnt == LAST_W)) begin
                            r_frameErr <= 1'b1;
                        end
                        if (r_cnt == LAST_W) begin
                            r_state  <= START;
                            r_cnt    <= '0;
                            r_sReady <= 1'b0;
                            r_start  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mv_status[0]) begin
                        r_state <= RD_ADDR;
                        r_cnt   <= '0;
                    end
                end
                RD_ADDR: begin
                    r_state <= RD_DATA;
                end
                RD_DATA: begin
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_outFire) begin
                        if (r_cnt == LAST_Y) begin
                            r_state <= RELEASE;
                            r_cnt   <= '0;
                            r_start <= 1'b0;
                        end else begin
                            r_state <= RD_ADDR;
                            r_cnt   <= r_cnt + ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!mv_status[0]) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // BRAM write strobes follow the accepted beat in the same cycle.
    always_comb begin
        bram_we_x = '0;
        bram_we_W = '0;
        bram_we_y = '0;
        if (r_state == LOAD_X && w_beat) begin
            bram_we_x = BE_ALL;
        end
        if (r_state == LOAD_W && w_beat) begin
            bram_we_W = BE_ALL;
        end
        if (r_state == CLR_Y) begin
            bram_we_y = BE_ALL;
        end
    end

    assign bram_addr_W   = addr_W_size'(w_byteAddr);
    assign bram_addr_x   = addr_x_size'(w_byteAddr);
    assign bram_addr_y   = addr_y_size'(w_byteAddr);
    assign bram_wrdata_W = s_axis_tdata;
    assign bram_wrdata_x = s_axis_tdata;
    assign bram_wrdata_y = '0;

    assign s_axis_tready = r_sReady;
    assign mv_control    = {31'b0, r_start};
    assign busy          = r_busy;
    assign frame_err     = r_frameErr;

    mv_axis_out_reg #(
        .DATA_W (32)
    ) u_outReg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_outLoad),
        .i_data  (bram_rddata_y),
        .i_last  (w_outLast),
        .i_ready (m_axis_tready),
        .o_data  (m_axis_tdata),
        .o_valid (m_axis_tvalid),
        .o_last  (m_axis_tlast),
        .o_fire  (w_outFire)
    );

endmodule
